// File: rtl/serial_xfer_ctrl.sv
// Serial transfer controller: 8-bit shift register clocked by an internal half-tick or an external sck_in.
// Define SERIAL_EXT_SYNC_EN to put a 2-flop synchronizer in front of the sck_in edge detector.
module serial_xfer_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       half_tick,
   input  logic       sck_in,
   input  logic       sin_in,
   input  logic       sb_wr,
   input  logic       sc_wr,
   input  logic [7:0] wdata,
   output logic [7:0] sb_rdata,
   output logic [7:0] sc_rdata,
   output logic       sck_out,
   output logic       sck_dir,
   output logic       ser_out,
   output logic       int_serial,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] sb;
   logic       start;
   logic       int_clk;
   logic [2:0] bit_cnt;
   logic       done;
   logic       sck_s;
   logic       sck_hist;
   logic       fall_evt;
   logic       rise_evt;

`ifdef SERIAL_EXT_SYNC_EN
   logic sck_m;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_m    <= 1'b0;
         sck_s    <= 1'b0;
         sck_hist <= 1'b0;
      end else begin
         sck_m    <= sck_in;
         sck_s    <= sck_m;
         sck_hist <= sck_s;
      end
   end
`else
   assign sck_s = sck_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sck_hist <= 1'b0;
      else       sck_hist <= sck_s;
   end
`endif

   // In internal mode each half_tick is the next edge; the current state decides its polarity.
   always_comb begin
      fall_evt = 1'b0;
      rise_evt = 1'b0;
      if (int_clk) begin
         fall_evt = half_tick;
         rise_evt = half_tick;
      end else begin
         fall_evt = ~sck_s & sck_hist;
         rise_evt = sck_s & ~sck_hist;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sb         <= '0;
         start      <= 1'b0;
         int_clk    <= 1'b0;
         bit_cnt    <= '0;
         done       <= 1'b0;
         ser_out    <= 1'b0;
         int_serial <= 1'b0;
         sck_out    <= 1'b1;
      end else begin
         int_serial <= done;
         done       <= 1'b0;
         if (sc_wr) begin
            start   <= wdata[7];
            int_clk <= wdata[0];
            bit_cnt <= '0;
            sck_out <= 1'b1;
            state   <= wdata[7] ? HIGH : IDLE;
         end else begin
            case (state)
               HIGH: begin
                  if (fall_evt) begin
                     state   <= LOW;
                     sck_out <= 1'b0;
                     ser_out <= sb[7];
                  end
               end
               LOW: begin
                  if (rise_evt) begin
                     sb      <= {sb[6:0], sin_in};
                     bit_cnt <= bit_cnt + 3'd1;
                     sck_out <= 1'b1;
                     if (bit_cnt == 3'd7) begin
                        state <= IDLE;
                        start <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state <= HIGH;
                     end
                  end
               end
               IDLE:    ;
               default: state <= IDLE;
            endcase
         end
         // A CPU write wins over a shift landing in the same cycle.
         if (sb_wr) sb <= wdata;
      end
   end

   assign sb_rdata = sb;
   assign sc_rdata = {start, 6'b111111, int_clk};
   assign sck_dir  = int_clk;
   assign busy     = start;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Self-checking bench for serial_xfer_ctrl: scenario tasks with queue-based expected serial bits and results.
module tb_serial_xfer_ctrl;

   logic       clk;
   logic       reset;
   logic       half_tick;
   logic       sck_in;
   logic       sin_in;
   logic       sb_wr;
   logic       sc_wr;
   logic [7:0] wdata;
   logic [7:0] sb_rdata;
   logic [7:0] sc_rdata;
   logic       sck_out;
   logic       sck_dir;
   logic       ser_out;
   logic       int_serial;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int int_cnt = 0;

   logic       ser_q[$];
   logic [7:0] sb_q[$];

   serial_xfer_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .half_tick  (half_tick),
      .sck_in     (sck_in),
      .sin_in     (sin_in),
      .sb_wr      (sb_wr),
      .sc_wr      (sc_wr),
      .wdata      (wdata),
      .sb_rdata   (sb_rdata),
      .sc_rdata   (sc_rdata),
      .sck_out    (sck_out),
      .sck_dir    (sck_dir),
      .ser_out    (ser_out),
      .int_serial (int_serial),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (int_serial === 1'b1) int_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (sb_rdata !== 8'h00) begin n_err++; $display("FAIL reset_sb: got %h want 00", sb_rdata); end
      n_cmp++; if (sc_rdata !== 8'h7E) begin n_err++; $display("FAIL reset_sc: got %h want 7e", sc_rdata); end
      n_cmp++; if ({sck_out, sck_dir, ser_out, int_serial, busy} !== 5'b10000) begin
         n_err++; $display("FAIL reset_pins: got %b want 10000", {sck_out, sck_dir, ser_out, int_serial, busy});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_internal();
      logic [7:0] pat = 8'hA5;
      logic       prev;
      logic       exp_bit;
      logic [7:0] exp_sb;
      int         got = -1;
      int         base;
      sb_wr = 1'b1; wdata = pat; tick(); sb_wr = 1'b0;
      for (int i = 7; i >= 0; i--) ser_q.push_back(pat[i]);
      sb_q.push_back(8'hFF);
      half_tick = 1'b1; sin_in = 1'b1; sc_wr = 1'b1; wdata = 8'h81;
      base = int_cnt; cyc = -1; tick(); sc_wr = 1'b0;
      prev = sck_out;
      repeat (40) begin
         tick();
         if (prev && !sck_out) begin
            n_cmp++;
            if (ser_q.size() == 0) begin n_err++; $display("FAIL int_ser_extra: unexpected falling sck at cycle %0d", cyc); end
            else begin
               exp_bit = ser_q.pop_front();
               if (ser_out !== exp_bit) begin n_err++; $display("FAIL int_ser_bit: got %b want %b at cycle %0d", ser_out, exp_bit, cyc); end
            end
         end
         prev = sck_out;
         if (int_serial && got < 0) begin
            got = cyc;
            exp_sb = sb_q.pop_front();
            n_cmp++; if (sb_rdata !== exp_sb) begin n_err++; $display("FAIL int_sb: got %h want %h", sb_rdata, exp_sb); end
         end
      end
      half_tick = 1'b0;
      n_cmp++; if (got !== 17) begin n_err++; $display("FAIL int_irq_cycle: got %0d want 17 (-1 means timeout)", got); end
      n_cmp++; if (int_cnt - base !== 1) begin n_err++; $display("FAIL int_irq_count: got %0d want 1", int_cnt - base); end
      n_cmp++; if (ser_q.size() !== 0) begin n_err++; $display("FAIL int_ser_count: %0d bits not seen want 0", ser_q.size()); end
      n_cmp++; if (sc_rdata !== 8'h7F) begin n_err++; $display("FAIL int_sc: got %h want 7f", sc_rdata); end
      n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL int_ser_hold: got %b want 1", ser_out); end
   endtask

   task automatic test_external();
      logic [7:0] pat = 8'h3C;
      logic [7:0] exp_sb;
      logic       dir_bad = 1'b0;
      logic       seen = 1'b0;
      int         base;
      half_tick = 1'b0; sck_in = 1'b1;
      repeat (4) tick();
      sb_q.push_back(pat);
      base = int_cnt;
      sc_wr = 1'b1; wdata = 8'h80; tick(); sc_wr = 1'b0;
      for (int b = 0; b < 8; b++) begin
         sck_in = 1'b0;
         repeat (4) begin tick(); if (sck_dir !== 1'b0) dir_bad = 1'b1; end
         sin_in = pat[7 - b];
         sck_in = 1'b1;
         if (b < 7) repeat (4) begin tick(); if (sck_dir !== 1'b0) dir_bad = 1'b1; end
      end
      repeat (12) begin
         tick();
         if (sck_dir !== 1'b0) dir_bad = 1'b1;
         if (int_serial && !seen) begin
            seen = 1'b1;
            exp_sb = sb_q.pop_front();
            n_cmp++; if (sb_rdata !== exp_sb) begin n_err++; $display("FAIL ext_sb: got %h want %h", sb_rdata, exp_sb); end
         end
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL ext_irq_timeout: got none want 1 pulse"); sb_q.delete(); end
      n_cmp++; if (int_cnt - base !== 1) begin n_err++; $display("FAIL ext_irq_count: got %0d want 1", int_cnt - base); end
      n_cmp++; if (dir_bad !== 1'b0) begin n_err++; $display("FAIL ext_sck_dir: got 1 at some cycle want 0"); end
   endtask

   task automatic test_abort();
      int base;
      sb_wr = 1'b1; wdata = 8'h5A; tick(); sb_wr = 1'b0;
      sin_in = 1'b0; half_tick = 1'b1; base = int_cnt;
      sc_wr = 1'b1; wdata = 8'h81; cyc = -1; tick(); sc_wr = 1'b0;
      repeat (6) tick();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_mid: got %b want 1", busy); end
      n_cmp++; if (sb_rdata !== 8'hD0) begin n_err++; $display("FAIL abort_sb_mid: got %h want d0", sb_rdata); end
      sc_wr = 1'b1; wdata = 8'h01; tick(); sc_wr = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
      repeat (20) tick();
      half_tick = 1'b0;
      n_cmp++; if (sb_rdata !== 8'hD0) begin n_err++; $display("FAIL abort_sb_frozen: got %h want d0", sb_rdata); end
      n_cmp++; if (int_cnt - base !== 0) begin n_err++; $display("FAIL abort_irq: got %0d want 0", int_cnt - base); end
      n_cmp++; if (sc_rdata !== 8'h7F) begin n_err++; $display("FAIL abort_sc: got %h want 7f", sc_rdata); end
      n_cmp++; if (sck_out !== 1'b1) begin n_err++; $display("FAIL abort_sck: got %b want 1", sck_out); end
   endtask

   task automatic test_reset_mid();
      int base;
      sb_wr = 1'b1; wdata = 8'h33; tick(); sb_wr = 1'b0;
      sin_in = 1'b1; half_tick = 1'b1; base = int_cnt;
      sc_wr = 1'b1; wdata = 8'h81; tick(); sc_wr = 1'b0;
      repeat (10) tick();
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (sb_rdata !== 8'h00) begin n_err++; $display("FAIL rmid_sb: got %h want 00", sb_rdata); end
      n_cmp++; if (sc_rdata !== 8'h7E) begin n_err++; $display("FAIL rmid_sc: got %h want 7e", sc_rdata); end
      n_cmp++; if ({sck_out, sck_dir, ser_out, int_serial, busy} !== 5'b10000) begin
         n_err++; $display("FAIL rmid_pins: got %b want 10000", {sck_out, sck_dir, ser_out, int_serial, busy});
      end
      tick();
      tick();
      reset = 1'b0;
      repeat (30) tick();
      half_tick = 1'b0;
      n_cmp++; if (int_cnt - base !== 0) begin n_err++; $display("FAIL rmid_irq: got %0d want 0", int_cnt - base); end
      n_cmp++; if (sb_rdata !== 8'h00) begin n_err++; $display("FAIL rmid_sb_after: got %h want 00", sb_rdata); end
   endtask

   task automatic test_coincident();
      logic [7:0] pat = 8'h96;
      logic [7:0] exp_sb;
      int         got = -1;
      int         e;
      int         k;
      sb_q.push_back(pat);
      half_tick = 1'b1;
      sc_wr = 1'b1; wdata = 8'h81; cyc = -1; tick(); sc_wr = 1'b0;
      repeat (50) begin
         e = cyc + 1;
         half_tick = (e % 2 == 0);
         k = (e - 1) / 4;
         if (k > 7) k = 7;
         sin_in = pat[7 - k];
         tick();
         if (int_serial && got < 0) begin
            got = cyc;
            exp_sb = sb_q.pop_front();
            n_cmp++; if (sb_rdata !== exp_sb) begin n_err++; $display("FAIL coin_sb: got %h want %h", sb_rdata, exp_sb); end
         end
      end
      half_tick = 1'b0;
      n_cmp++; if (got !== 33) begin n_err++; $display("FAIL coin_irq_cycle: got %0d want 33 (-1 means timeout)", got); if (got < 0) sb_q.delete(); end
   endtask

   task automatic test_sb_overwrite();
      logic [7:0] exp_sb;
      int         got = -1;
      sb_wr = 1'b1; wdata = 8'hFF; tick(); sb_wr = 1'b0;
      sb_q.push_back(8'h0F);
      sin_in = 1'b1; half_tick = 1'b1;
      sc_wr = 1'b1; wdata = 8'h81; cyc = -1; tick(); sc_wr = 1'b0;
      repeat (8) tick();
      sb_wr = 1'b1; wdata = 8'h00; tick(); sb_wr = 1'b0;
      repeat (30) begin
         tick();
         if (int_serial && got < 0) begin
            got = cyc;
            exp_sb = sb_q.pop_front();
            n_cmp++; if (sb_rdata !== exp_sb) begin n_err++; $display("FAIL ovw_sb: got %h want %h", sb_rdata, exp_sb); end
         end
      end
      half_tick = 1'b0;
      n_cmp++; if (got !== 17) begin n_err++; $display("FAIL ovw_irq_cycle: got %0d want 17 (-1 means timeout)", got); if (got < 0) sb_q.delete(); end
   endtask

   initial begin
      reset = 1'b1; half_tick = 1'b0; sck_in = 1'b1; sin_in = 1'b0;
      sb_wr = 1'b0; sc_wr = 1'b0; wdata = 8'h00;
      test_reset();
      test_internal();
      test_external();
      test_abort();
      test_reset_mid();
      test_coincident();
      test_sb_overwrite();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_xfer_ctrl.md
SERIAL_XFER_CTRL -- requirements
Module: serial_xfer_ctrl

Interface
REQ-001 SHALL provide port clk, input, 1: the single block clock; all state updates on its rising edge.
REQ-002 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL provide port half_tick, input, 1: one-clk pulse at 16384 Hz, giving the internal shift-clock half-period.
REQ-004 SHALL provide port sck_in, input, 1: external shift clock, asynchronous to clk.
REQ-005 SHALL provide port sin_in, input, 1: serial data in.
REQ-006 SHALL provide port sb_wr, input, 1: write strobe for the data register (FF01).
REQ-007 SHALL provide port sc_wr, input, 1: write strobe for the control register (FF02).
REQ-008 SHALL provide port wdata, input, 8: CPU write data.
REQ-009 SHALL provide port sb_rdata, output, 8: current shift register contents.
REQ-010 SHALL provide port sc_rdata, output, 8: {start, 6'b111111, int_clk}.
REQ-011 SHALL provide port sck_out, output, 1: internal shift clock driven to the pin.
REQ-012 SHALL provide port sck_dir, output, 1: 1 = pin driven (internal clock mode).
REQ-013 SHALL provide port ser_out, output, 1: serial data out.
REQ-014 SHALL provide port int_serial, output, 1: one-clk transfer-complete pulse.
REQ-015 SHALL provide port busy, output, 1: equal to the start bit.

Function
REQ-016 SHALL hold an 8-bit shift register sb, a start bit, an int_clk bit, a 3-bit bit counter and a state machine with states IDLE, LOW and HIGH.
REQ-017 SHALL update sb with wdata on sb_wr in any state; this overwrites the shift register, including mid-transfer.
REQ-018 SHALL load start=wdata[7] and int_clk=wdata[0] on sc_wr, zero the bit counter, and enter HIGH if wdata[7] is 1, otherwise IDLE.
REQ-019 SHALL drive sck_dir from int_clk and sck_out=1 in IDLE and HIGH and sck_out=0 in LOW.
REQ-020 SHALL use as clock event a half_tick pulse when int_clk=1, or a detected edge of the synchronized sck_in when int_clk=0.
REQ-021 SHALL, on a falling event in HIGH, enter LOW and set ser_out=sb[7] (data out changes on falling edge).
REQ-022 SHALL, on a rising event in LOW, set sb={sb[6:0], sin_in} and increment the counter; the sin_in sample is taken in the same clk as the event.
REQ-023 SHALL, on the 8th rising event (counter wraps 7->0), clear start, enter IDLE and assert int_serial for exactly one clk on the following cycle.
REQ-024 SHALL ignore clock events in IDLE; external edges of the wrong polarity for the current state are ignored.
REQ-025 SHALL give sc_wr priority over a simultaneous clock event, which is discarded; sb_wr together with a rising event SHALL take wdata, and that shift is lost.
REQ-026 SHALL abort a transfer on sc_wr with wdata[7]=0 mid-transfer: no interrupt, counter cleared, sb keeps its partially shifted value.
REQ-027 SHALL hold ser_out at its last value when idle.
REQ-028 SHALL take, at half_tick=1 constantly in internal mode, 16 clk from start to int_serial +1.

Reset
REQ-029 SHALL, while reset is asserted, force sb=8'h00, start=0, int_clk=0, counter=0, state=IDLE, ser_out=0, int_serial=0, sck_out=1, sck_dir=0 and clear the sck_in synchronizer and edge history.
REQ-030 SHALL, on reset mid-transfer, abandon the transfer with no interrupt pulse, then or later.

Configuration
REQ-031 SHALL, with SERIAL_EXT_SYNC_EN defined, pass sck_in through a 2-flop synchronizer before edge detection, so external edges act 3 clk after the pin changes.
REQ-032 SHALL, without SERIAL_EXT_SYNC_EN, detect edges on sck_in against a single history flop, acting 1 clk after the pin changes, for cycle-matched gate-level comparison; internal mode is identical either way.

Verification
REQ-033 SHALL cover: sb_wr 8'hA5, sc_wr 8'h81, half_tick every clk -> ser_out sequence 1,0,1,0,0,1,0,1; sin_in=1 gives sb=8'hFF; one int_serial pulse; sc_rdata=8'h7F.
REQ-034 SHALL cover: sc_wr 8'h80 with 8 external sck_in periods carrying sin_in bits 0x3C MSB first -> sb_rdata=8'h3C, int_serial once, sck_dir=0 throughout.
REQ-035 SHALL cover: sc_wr 8'h81 then, after 3 rising events, sc_wr 8'h01 -> busy=0, no int_serial, further half_tick pulses cause no shift.
REQ-036 SHALL cover: reset asserted after 5 bits -> all REQ-029 values immediately (asynchronously), no int_serial after release.
REQ-037 SHALL cover: sc_wr 8'h81 coincident with a half_tick -> that tick ignored, 8 full bits still shifted, int_serial on the expected cycle.
REQ-038 SHALL cover: sb_wr 8'h00 mid-transfer at bit 4 -> remaining 4 bits shift from 8'h00, completion still at 8 total rising events.
